// File: rtl/serial_pair_transmitter.sv
// Serialises an (a, b) operand pair one bit per clock with first/last framing.
// Define SERIAL_PAIR_TX_LSB_FIRST_EN to send bit 0 first; default sends MSB first.
module serial_pair_transmitter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    output logic         out_a,
    output logic         out_b,
    output logic         out_first,
    output logic         out_last,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_sh_a;
    logic [W-1:0]   r_sh_b;
    logic           r_first;
    logic           r_last;
    logic           w_xfer;

    // Handshake: a pair transfers when in_valid & in_ready at a rising edge.
    // in_ready is high while idle and on the last bit of a word, which lets
    // the next pair load with no bubble between words.
    assign in_ready = (r_state == ST_IDLE) | r_last;
    assign w_xfer   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if ((r_state == ST_IDLE) || r_last) begin
            if (w_xfer) begin
                r_state <= ST_SHIFT;
                r_cnt   <= CW'(W - 1);
                r_sh_a  <= in_a;
                r_sh_b  <= in_b;
                r_first <= 1'b1;
                r_last  <= (W == 1);
            end else begin
                // Clearing the shift registers keeps out_a/out_b low while idle.
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_sh_a  <= '0;
                r_sh_b  <= '0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end else begin
`ifdef SERIAL_PAIR_TX_LSB_FIRST_EN
            r_sh_a  <= r_sh_a >> 1;
            r_sh_b  <= r_sh_b >> 1;
`else
            r_sh_a  <= r_sh_a << 1;
            r_sh_b  <= r_sh_b << 1;
`endif
            r_cnt   <= r_cnt - CW'(1);
            r_first <= 1'b0;
            r_last  <= (r_cnt == CW'(1));
        end
    end

`ifdef SERIAL_PAIR_TX_LSB_FIRST_EN
    assign out_a = r_sh_a[0];
    assign out_b = r_sh_b[0];
`else
    assign out_a = r_sh_a[W-1];
    assign out_b = r_sh_b[W-1];
`endif

    assign out_valid = (r_state == ST_SHIFT);
    assign busy      = (r_state == ST_SHIFT);
    assign out_first = r_first;
    assign out_last  = r_last;

endmodule

// File: tb/tb_serial_pair_transmitter.sv
// Bench for serial_pair_transmitter: W=8 and W=1 instances against a bit-stream queue model.
module tb_serial_pair_transmitter;

    localparam int W = 8;
`ifdef SERIAL_PAIR_TX_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_a, out_b, out_first, out_last, busy;
    logic [W-1:0] in_a, in_b;
    logic         in_valid1, in_ready1, out_valid1, out_a1, out_b1, out_first1, out_last1, busy1;
    logic [0:0]   in_a1, in_b1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Each entry is one expected serial cycle: {a_bit, b_bit, first, last}.
    logic [3:0] exp_q[$];
    logic [3:0] exp1_q[$];

    serial_pair_transmitter #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_a(out_a),
        .out_b(out_b), .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    serial_pair_transmitter #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1), .out_a(out_a1),
        .out_b(out_b1), .out_first(out_first1), .out_last(out_last1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] a, input logic [W-1:0] b);
        int idx;
        for (int i = 0; i < W; i++) begin
            idx = LSB ? i : (W - 1 - i);
            exp_q.push_back({a[idx], b[idx], (i == 0), (i == W - 1)});
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_a"},     out_a, 0);
        chk({tag, "_b"},     out_b, 0);
        chk({tag, "_first"}, out_first, 0);
        chk({tag, "_last"},  out_last, 0);
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_valid1"}, out_valid1, 0);
        chk({tag, "_ready1"}, in_ready1, 1);
    endtask

    // Called at a negedge: drive inputs, compare outputs to the model, advance one clock.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic v1, input logic a1, input logic b1);
        logic [3:0] e, e1;
        logic       rdy_m, rdy1_m;
        in_valid  = v;  in_a  = a;  in_b  = b;
        in_valid1 = v1; in_a1 = a1; in_b1 = b1;
        e      = (exp_q.size()  != 0) ? exp_q[0]  : 4'b0000;
        e1     = (exp1_q.size() != 0) ? exp1_q[0] : 4'b0000;
        rdy_m  = (exp_q.size()  <= 1);
        rdy1_m = (exp1_q.size() <= 1);
        chk("valid", out_valid, exp_q.size() != 0);
        chk("busy",  busy,      exp_q.size() != 0);
        chk("out_a", out_a,     e[3]);
        chk("out_b", out_b,     e[2]);
        chk("first", out_first, e[1]);
        chk("last",  out_last,  e[0]);
        chk("ready", in_ready,  rdy_m);
        chk("w1_valid", out_valid1, exp1_q.size() != 0);
        chk("w1_a",     out_a1,     e1[3]);
        chk("w1_b",     out_b1,     e1[2]);
        chk("w1_first", out_first1, e1[1]);
        chk("w1_last",  out_last1,  e1[0]);
        chk("w1_ready", in_ready1,  rdy1_m);
        @(posedge clk);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (exp1_q.size() != 0) void'(exp1_q.pop_front());
        if (v && rdy_m) push_word(a, b);
        if (v1 && rdy1_m) exp1_q.push_back({a1, b1, 1'b1, 1'b1});
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, W'($urandom), W'($urandom), 1'b0, 1'($urandom), 1'($urandom));
    endtask

    initial begin
        logic [W-1:0] pa[2];
        logic [W-1:0] pb[2];
        int           idx;
        logic         acc;

        rst = 1'b1;
        in_valid = 0; in_a = '0; in_b = '0;
        in_valid1 = 0; in_a1 = '0; in_b1 = '0;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single word A5/3C, and W=1 pairs (1,0),(0,1) streamed.
        step(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        idle_steps(10);

        // Back-to-back with in_valid held high.
        pa[0] = 8'hFF; pb[0] = 8'h00;
        pa[1] = 8'h01; pb[1] = 8'h80;
        idx = 0;
        while (idx < 2) begin
            acc = (exp_q.size() <= 1);
            step(1'b1, pa[idx], pb[idx], 1'b1, 1'($urandom), 1'($urandom));
            if (acc) idx++;
        end
        idle_steps(18);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
                 $urandom_range(0, 1) == 1, 1'($urandom), 1'($urandom));
        idle_steps(10);

        // Asynchronous reset in the middle of a word.
        step(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1);
        idle_steps(3);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        exp_q.delete();
        exp1_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        step(1'b1, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
        idle_steps(10);

        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 4) != 0, W'($urandom), W'($urandom),
                 $urandom_range(0, 1) == 1, 1'($urandom), 1'($urandom));
        idle_steps(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
